if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 143 ++++++++++++++
 tb/tb_if_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word-aligned memory requests, tracks in-flight
// instructions against DEPTH, and buffers in-order responses with their pc for decode.
module if_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_pc_vld,
  output logic        o_pc_rdy,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvld,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pend_pc_q  [DEPTH];
  logic [31:0]   pend_pc_d  [DEPTH];
  logic [AW-1:0] pend_wr_q, pend_wr_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;

  logic [31:0]   out_pc_q   [DEPTH];
  logic [31:0]   out_pc_d   [DEPTH];
  logic [31:0]   out_inst_q [DEPTH];
  logic [31:0]   out_inst_d [DEPTH];
  logic [AW-1:0] out_wr_q, out_wr_d;
  logic [AW-1:0] out_rd_q, out_rd_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  // outst counts every granted-but-unreturned request, discarded ones included
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [CW-1:0] in_flight_s;
  logic          accept_s;
  logic          rsp_s;
  logic          keep_s;
  logic          pop_s;

  // Request handshake and response classification
  always_comb begin
    in_flight_s = outst_q + out_cnt_q;
    o_imem_req  = !i_rst && i_pc_vld && !i_flush && (in_flight_s < CW'(DEPTH));
    o_imem_addr = {i_pc[31:2], 2'b00};
    accept_s    = o_imem_req && i_imem_gnt;
    o_pc_rdy    = accept_s;
    // a response with nothing outstanding is a protocol error and is ignored
    rsp_s       = i_imem_rvld && (outst_q != {CW{1'b0}});
    keep_s      = rsp_s && !i_flush && (disc_q == {CW{1'b0}});
    pop_s       = o_inst_vld && i_inst_rdy && !i_flush;
    o_inst_vld  = (out_cnt_q != {CW{1'b0}});
    o_inst      = out_inst_q[out_rd_q];
    o_inst_pc   = out_pc_q[out_rd_q];
  end

  // Next-state for both FIFOs and the outstanding/discard counters
  always_comb begin
    pend_pc_d  = pend_pc_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    out_wr_d   = out_wr_q;
    out_rd_d   = out_rd_q;
    out_cnt_d  = out_cnt_q;
    disc_d     = disc_q;
    outst_d    = outst_q + CW'(accept_s) - CW'(rsp_s);

    if (i_flush) begin
      pend_wr_d = {AW{1'b0}};
      pend_rd_d = {AW{1'b0}};
      out_wr_d  = {AW{1'b0}};
      out_rd_d  = {AW{1'b0}};
      out_cnt_d = {CW{1'b0}};
      disc_d    = outst_q - CW'(rsp_s);
    end else begin
      if (accept_s) begin
        pend_pc_d[pend_wr_q] = i_pc;
        pend_wr_d            = pend_wr_q + AW'(1);
      end else begin
        pend_wr_d = pend_wr_q;
      end

      if (keep_s) begin
        pend_rd_d            = pend_rd_q + AW'(1);
        out_pc_d[out_wr_q]   = pend_pc_q[pend_rd_q];
        out_inst_d[out_wr_q] = i_imem_rdata;
        out_wr_d             = out_wr_q + AW'(1);
      end else if (rsp_s) begin
        disc_d = disc_q - CW'(1);
      end else begin
        disc_d = disc_q;
      end

      if (pop_s) begin
        out_rd_d = out_rd_q + AW'(1);
      end else begin
        out_rd_d = out_rd_q;
      end

      out_cnt_d = out_cnt_q + CW'(keep_s) - CW'(pop_s);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend_pc_q[i]  <= 32'h0000_0000;
        out_pc_q[i]   <= 32'h0000_0000;
        out_inst_q[i] <= 32'h0000_0000;
      end
      pend_wr_q <= {AW{1'b0}};
      pend_rd_q <= {AW{1'b0}};
      out_wr_q  <= {AW{1'b0}};
      out_rd_q  <= {AW{1'b0}};
      out_cnt_q <= {CW{1'b0}};
      outst_q   <= {CW{1'b0}};
      disc_q    <= {CW{1'b0}};
    end else begin
      pend_pc_q  <= pend_pc_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: an in-order memory model plus a queue-based
// reference of the fetch buffer, with directed scenarios ahead of the random run.
module tb_if_fetch;
  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_pc = 32'h0;
  logic        i_pc_vld = 1'b0;
  logic        o_pc_rdy;
  logic        i_flush = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvld = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_inst_vld;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_rdy = 1'b0;

  if_fetch #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_pc_vld(i_pc_vld), .o_pc_rdy(o_pc_rdy),
    .i_flush(i_flush), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvld(i_imem_rvld), .i_imem_rdata(i_imem_rdata),
    .o_inst_vld(o_inst_vld), .o_inst(o_inst), .o_inst_pc(o_inst_pc), .i_inst_rdy(i_inst_rdy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  int          n_chk = 0;
  int          n_err = 0;
  ent_t        outq[$];
  logic [31:0] pendq[$];
  logic [31:0] mem_addr[$];
  int          mem_cyc[$];
  int          disc = 0;
  int          cyc = 0;
  logic        seen_req;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    outq.delete();
    pendq.delete();
    mem_addr.delete();
    mem_cyc.delete();
    disc = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_pc_vld = 1'b1; i_imem_gnt = 1'b1; i_flush = 1'b0;
    i_imem_rvld = 1'b0; i_inst_rdy = 1'b0; i_pc = 32'h0;
    #1;
    check("rst_req", {31'b0, o_imem_req}, 32'h0);
    check("rst_pc_rdy", {31'b0, o_pc_rdy}, 32'h0);
    check("rst_vld", {31'b0, o_inst_vld}, 32'h0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_inst_pc", o_inst_pc, 32'h0);
    model_clear();
    i_pc_vld = 1'b0; i_imem_gnt = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic pv, input logic [31:0] pc, input logic gnt, input logic fl,
                      input logic rdy, input logic rv, input logic bad);
    int   infl;
    logic ereq, acc, rsp, pop;
    ent_t e;
    @(negedge i_clk);
    rsp = rv && (mem_addr.size() > 0) && (mem_cyc[0] < cyc);
    i_pc_vld = pv; i_pc = pc; i_imem_gnt = gnt; i_flush = fl; i_inst_rdy = rdy;
    i_imem_rvld  = rsp || (bad && mem_addr.size() == 0);
    i_imem_rdata = rsp ? mem_data(mem_addr[0]) : $urandom;
    #1;
    infl = mem_addr.size() + outq.size();
    ereq = pv && !fl && (infl < DEPTH);
    acc  = ereq && gnt;
    pop  = (outq.size() > 0) && rdy;
    seen_req = o_imem_req;
    check("imem_req", {31'b0, o_imem_req}, {31'b0, ereq});
    check("pc_rdy", {31'b0, o_pc_rdy}, {31'b0, acc});
    check("imem_addr", o_imem_addr, {pc[31:2], 2'b00});
    check("inst_vld", {31'b0, o_inst_vld}, {31'b0, outq.size() > 0});
    if (outq.size() > 0) begin
      check("inst", o_inst, outq[0].inst);
      check("inst_pc", o_inst_pc, outq[0].pc);
    end
    @(posedge i_clk);
    if (fl) begin
      outq.delete();
      pendq.delete();
      disc = mem_addr.size() - (rsp ? 1 : 0);
    end else begin
      if (pop) void'(outq.pop_front());
      if (rsp) begin
        if (disc > 0) disc--;
        else begin
          e.pc   = pendq.pop_front();
          e.inst = i_imem_rdata;
          outq.push_back(e);
        end
      end
      if (acc) pendq.push_back(pc);
    end
    if (rsp) begin
      void'(mem_addr.pop_front());
      void'(mem_cyc.pop_front());
    end
    if (acc) begin
      mem_addr.push_back({pc[31:2], 2'b00});
      mem_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  initial begin
    do_reset();

    // first fetch of pc 0 returns 0x13 one edge after the response
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("first_vld", {31'b0, o_inst_vld}, 32'h1);
    check("first_inst", o_inst, 32'h0000_0013);
    check("first_pc", o_inst_pc, 32'h0000_0000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // decode stalled: only DEPTH fetches go out, one pop re-opens requests
    do_reset();
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_req", {31'b0, seen_req}, 32'h0);
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stall_req2", {31'b0, seen_req}, 32'h0);
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reopen_req", {31'b0, seen_req}, 32'h1);

    // flush with two outstanding: both responses dropped, 0x100 comes out first
    do_reset();
    step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_drop_vld", {31'b0, o_inst_vld}, 32'h0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("flush_first_pc", o_inst_pc, 32'h0000_0100);

    // unaligned pc keeps its low bits on the instruction
    do_reset();
    step(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    check("unaligned_pc", o_inst_pc, 32'h0000_0006);
    check("unaligned_inst", o_inst, mem_data(32'h4));

    // reset between grant and response
    do_reset();
    step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge i_clk);
    i_pc_vld = 1'b1; i_imem_gnt = 1'b1; i_imem_rvld = 1'b0; i_inst_rdy = 1'b0;
    #1;
    check("pre_rst_vld", {31'b0, o_inst_vld}, 32'h1);
    #1;
    i_rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'b0, o_inst_vld}, 32'h0);
    check("mid_rst_inst", o_inst, 32'h0);
    check("mid_rst_pc", o_inst_pc, 32'h0);
    check("mid_rst_req", {31'b0, o_imem_req}, 32'h0);
    check("mid_rst_rdy", {31'b0, o_pc_rdy}, 32'h0);
    model_clear();
    i_pc_vld = 1'b0; i_imem_gnt = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic including flushes and spurious responses
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(3, 0) != 0, $urandom, $urandom_range(2, 0) != 0,
           $urandom_range(19, 0) == 0, $urandom_range(1, 0) == 1,
           $urandom_range(1, 0) == 1, $urandom_range(29, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
